// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller states, padding constants, block sizing
// and the round-constant table used by the compression core.
package sha256_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      OUT
   } state_t;

   localparam logic [31:0] PAD_WORD = 32'h8000_0000;

   // Message bits + the mandatory 1 bit + 64-bit length, rounded up to 512-bit blocks.
   function automatic int unsigned num_blocks(input int unsigned words);
      return (32 * words + 65 + 511) / 512;
   endfunction

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

endpackage

// File: rtl/sha256_pad_word.sv
// Selects one 32-bit word of a padded block: message data, the 1-bit marker,
// the bit-length word, or zero fill.
import sha256_pkg::*;

module sha256_pad_word (
   input  logic [15:0] g,
   input  logic [3:0]  w,
   input  logic        is_last,
   input  logic [15:0] n,
   input  logic [31:0] mem_read_data,
   output logic [31:0] word
);

   always_comb begin
      word = '0;
      if (g < n) begin
         word = mem_read_data;
      end else if (g == n) begin
         word = PAD_WORD;
      end else if (is_last && (w == 4'd15)) begin
         // Length low word; the high word (w == 14) stays zero for N <= 1000.
         word = {11'b0, n, 5'b0};
      end
   end

endmodule

// File: rtl/sha256_block_padder.sv
// Fetches an N-word message from memory, applies SHA-256 padding and streams
// the result as 512-bit blocks over a valid/ready handshake.
import sha256_pkg::*;

module sha256_block_padder #(
   parameter int unsigned NUM_OF_WORDS = 20
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [15:0]  message_addr,
   output logic         done,
   output logic         mem_clk,
   output logic         mem_we,
   output logic [15:0]  mem_addr,
   input  logic [31:0]  mem_read_data,
   output logic         block_valid,
   input  logic         block_ready,
   output logic [511:0] block_data,
   output logic         block_last,
   output logic [7:0]   block_index
);

   localparam int unsigned NUM_BLOCKS = num_blocks(NUM_OF_WORDS);
   localparam logic [7:0]  LAST_INDEX = 8'(NUM_BLOCKS - 1);
   localparam logic [15:0] N16        = 16'(NUM_OF_WORDS);

   state_t      state;
   state_t      state_next;
   logic [4:0]  slot_cnt;
   logic [15:0] base_addr;
   logic        is_last;
   logic [3:0]  cap_w;
   logic [15:0] cap_g;
   logic [15:0] fetch_g;
   logic [7:0]  next_index;
   logic [31:0] pad_word;

   assign mem_clk    = clk;
   assign mem_we     = 1'b0;
   assign done       = (state == IDLE);
   assign is_last    = (block_index == LAST_INDEX);
   assign next_index = block_index + 8'd1;

   // slot_cnt 0 is the address-lead cycle; slot_cnt k captures word k-1 while
   // the address for word k+1 is issued.
   assign cap_w   = 4'(slot_cnt - 5'd1);
   assign cap_g   = {4'b0, block_index, cap_w};
   assign fetch_g = {4'b0, block_index, 4'b0} + 16'(slot_cnt) + 16'd1;

   sha256_pad_word u_pad_word (
      .g             (cap_g),
      .w             (cap_w),
      .is_last       (is_last),
      .n             (N16),
      .mem_read_data (mem_read_data),
      .word          (pad_word)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = FILL;
         FILL: if (slot_cnt == 5'd16) state_next = OUT;
         OUT: begin
            if (block_ready) begin
               state_next = is_last ? IDLE : FILL;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         slot_cnt    <= '0;
         base_addr   <= '0;
         mem_addr    <= '0;
         block_index <= '0;
         block_data  <= '0;
         block_valid <= 1'b0;
         block_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  base_addr   <= message_addr;
                  mem_addr    <= message_addr;
                  block_index <= '0;
                  slot_cnt    <= '0;
               end
            end
            FILL: begin
               slot_cnt <= slot_cnt + 5'd1;
               mem_addr <= base_addr + fetch_g;
               // Words shift in from the bottom so word 0 ends up in [511:480].
               if (slot_cnt != 5'd0) begin
                  block_data <= {block_data[479:0], pad_word};
               end
               if (slot_cnt == 5'd16) begin
                  block_valid <= 1'b1;
                  block_last  <= is_last;
               end
            end
            OUT: begin
               if (block_ready) begin
                  block_valid <= 1'b0;
                  block_last  <= 1'b0;
                  if (!is_last) begin
                     block_index <= next_index;
                     slot_cnt    <= '0;
                     mem_addr    <= base_addr + {4'b0, next_index, 4'b0};
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_block_padder.sv
// Scoreboard bench: four padder instances (N = 20, 13, 14, 16) share one memory image.
module tb_sha256_block_padder;

   localparam int NW [4] = '{20, 13, 14, 16};

   typedef struct {
      logic [511:0] data;
      logic         last;
      logic [7:0]   idx;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start_s  [4];
   logic [15:0]  maddr_in [4];
   logic         done_s   [4];
   logic         mclk     [4];
   logic         mwe      [4];
   logic [15:0]  maddr    [4];
   logic [31:0]  rdata    [4];
   logic         valid    [4];
   logic         ready    [4];
   logic [511:0] bdata    [4];
   logic         blast    [4];
   logic [7:0]   bidx     [4];

   logic [31:0] mem [0:65535];
   exp_t        sb [$];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < 4; i++) begin : g_dut
      sha256_block_padder #(.NUM_OF_WORDS(NW[i])) dut (
         .clk           (clk),
         .reset_n       (reset_n),
         .start         (start_s[i]),
         .message_addr  (maddr_in[i]),
         .done          (done_s[i]),
         .mem_clk       (mclk[i]),
         .mem_we        (mwe[i]),
         .mem_addr      (maddr[i]),
         .mem_read_data (rdata[i]),
         .block_valid   (valid[i]),
         .block_ready   (ready[i]),
         .block_data    (bdata[i]),
         .block_last    (blast[i]),
         .block_index   (bidx[i])
      );
   end

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) rdata[i] <= mem[maddr[i]];
   end

   function automatic logic [31:0] exp_word(input int n, input int b, input int w,
                                            input logic [15:0] base);
      int nb;
      int g;
      logic [15:0] a;
      nb = (32 * n + 65 + 511) / 512;
      g  = 16 * b + w;
      if (g < n) begin
         a = base + 16'(g);
         return mem[a];
      end
      if (g == n) return 32'h8000_0000;
      if ((b == nb - 1) && (w == 15)) return 32'(n * 32);
      return 32'h0;
   endfunction

   task automatic run_message(input int d, input logic [15:0] addr, input int bp,
                              input bit noise, input string name);
      int nb;
      int cyc;
      int budget;
      int seen;
      bit finished;
      exp_t e;
      logic [511:0] held;
      nb = (32 * NW[d] + 65 + 511) / 512;
      for (int b = 0; b < nb; b++) begin
         e.data = '0;
         for (int w = 0; w < 16; w++) e.data[511 - 32 * w -: 32] = exp_word(NW[d], b, w, addr);
         e.last = (b == nb - 1);
         e.idx  = 8'(b);
         sb.push_back(e);
      end
      @(negedge clk);
      start_s[d]  = 1'b1;
      maddr_in[d] = addr;
      @(posedge clk); #1;
      start_s[d]  = 1'b0;
      maddr_in[d] = 16'hDEAD;
      cyc = 0; budget = 0; seen = 0; finished = 0;
      while (!finished && budget < 40 * nb + bp + 100) begin
         @(posedge clk); #1;
         cyc++; budget++;
         if (!valid[d]) begin
            if (cyc == 1 && seen == 0) begin
               tests++;
               if (done_s[d] !== 1'b0) begin
                  fails++; $display("FAIL %s done_busy: got %b expected 0", name, done_s[d]);
               end
            end
            if (noise) begin
               start_s[d] = 1'($urandom);
               ready[d]   = 1'($urandom);
            end
            continue;
         end
         ready[d] = 1'b0;
         tests++;
         if (cyc != 17) begin
            fails++; $display("FAIL %s latency: got %0d cycles expected 17", name, cyc);
         end
         if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL %s extra_block: got index %0d expected no block", name, bidx[d]);
            break;
         end
         e = sb.pop_front();
         tests += 3;
         if (bdata[d] !== e.data) begin
            fails++; $display("FAIL %s data[%0d]: got %h expected %h", name, e.idx, bdata[d], e.data);
         end
         if (blast[d] !== e.last) begin
            fails++; $display("FAIL %s last[%0d]: got %b expected %b", name, e.idx, blast[d], e.last);
         end
         if (bidx[d] !== e.idx) begin
            fails++; $display("FAIL %s index: got %0d expected %0d", name, bidx[d], e.idx);
         end
         held = bdata[d];
         for (int k = 0; k < bp; k++) begin
            if (noise) start_s[d] = 1'($urandom);
            @(posedge clk); #1;
            budget++;
            tests++;
            if (valid[d] !== 1'b1 || bdata[d] !== held || bidx[d] !== e.idx) begin
               fails++;
               $display("FAIL %s stall%0d: got valid %b idx %0d expected valid 1 idx %0d, data held",
                        name, k, valid[d], bidx[d], e.idx);
            end
         end
         ready[d] = 1'b1;
         @(posedge clk); #1;
         ready[d]   = 1'b0;
         start_s[d] = 1'b0;
         seen++;
         tests++;
         if (valid[d] !== 1'b0) begin
            fails++; $display("FAIL %s valid_drop: got %b expected 0", name, valid[d]);
         end
         cyc = 0;
         if (e.last) finished = 1;
      end
      start_s[d] = 1'b0;
      ready[d]   = 1'b0;
      tests += 3;
      if (!finished) begin
         fails++; $display("FAIL %s timeout: got %0d blocks expected %0d", name, seen, nb);
      end
      if (sb.size() != 0) begin
         fails++; $display("FAIL %s leftover: got %0d pending expected 0", name, sb.size());
         sb.delete();
      end
      @(posedge clk); #1;
      if (done_s[d] !== 1'b1 || valid[d] !== 1'b0) begin
         fails++; $display("FAIL %s idle_after: got done %b valid %b expected 1 0", name, done_s[d], valid[d]);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
         tests += 3;
         if (done_s[d] !== 1'b1 || valid[d] !== 1'b0 || blast[d] !== 1'b0) begin
            fails++; $display("FAIL reset_ctl%0d: got done %b valid %b last %b expected 1 0 0",
                              d, done_s[d], valid[d], blast[d]);
         end
         if (bidx[d] !== 8'd0 || maddr[d] !== 16'd0 || bdata[d] !== '0) begin
            fails++; $display("FAIL reset_regs%0d: got idx %0d addr %h data %h expected zeros",
                              d, bidx[d], maddr[d], bdata[d]);
         end
         if (mwe[d] !== 1'b0 || mclk[d] !== clk) begin
            fails++; $display("FAIL mem_ctl%0d: got we %b mem_clk %b expected 0 %b", d, mwe[d], mclk[d], clk);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_basic_n20();
      run_message(0, 16'h0100, 0, 0, "n20");
   endtask

   task automatic test_single_block_n13();
      run_message(1, 16'h0100, 0, 0, "n13");
   endtask

   task automatic test_boundaries();
      run_message(2, 16'h0100, 0, 0, "n14");
      run_message(3, 16'h0100, 0, 0, "n16");
   endtask

   task automatic test_backpressure();
      run_message(0, 16'h0100, 10, 0, "bp");
   endtask

   task automatic test_addr_wrap();
      run_message(0, 16'hFFF8, 3, 0, "wrap");
   endtask

   task automatic test_noise();
      run_message(0, 16'h0200, 2, 1, "noise_n20");
      run_message(2, 16'h0300, 0, 1, "noise_n14");
   endtask

   task automatic test_reset_mid_fill();
      int k;
      @(negedge clk);
      start_s[0]  = 1'b1;
      maddr_in[0] = 16'h0100;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      k = 0;
      while (!valid[0] && k < 40) begin
         @(posedge clk); #1; k++;
      end
      ready[0] = 1'b1;
      @(posedge clk); #1;
      ready[0] = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk); #1;
      tests += 2;
      if (done_s[0] !== 1'b1 || valid[0] !== 1'b0) begin
         fails++; $display("FAIL midreset_state: got done %b valid %b expected 1 0", done_s[0], valid[0]);
      end
      if (bidx[0] !== 8'd0 || k >= 40) begin
         fails++; $display("FAIL midreset_index: got idx %0d wait %0d expected idx 0 wait < 40", bidx[0], k);
      end
      @(negedge clk);
      reset_n = 1'b1;
      k = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (valid[0] !== 1'b0) k++;
      end
      tests++;
      if (k != 0) begin
         fails++; $display("FAIL midreset_quiet: got %0d valid cycles expected 0", k);
      end
      run_message(0, 16'h0100, 0, 0, "after_reset");
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 32'hA500_0000 ^ 32'(a);
      for (int i = 0; i < 1000; i++) mem[16'h0100 + i] = 32'(i + 1);
      for (int d = 0; d < 4; d++) begin
         start_s[d]  = 1'b0;
         ready[d]    = 1'b0;
         maddr_in[d] = 16'h0000;
      end
      reset_n = 1'b0;
      test_reset();
      test_basic_n20();
      test_single_block_n13();
      test_boundaries();
      test_backpressure();
      test_addr_wrap();
      test_reset_mid_fill();
      test_noise();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
